proc_out_fifo: RTL

- Output-side buffer directly downstream of the Processor's 16-bit dout port.
- Captures each word the processor writes to its output port, queues it in a FIFO, and hands it to a consumer over a valid/ready handshake.
- Decouples processor execution from slow output consumers.
- Flags words that are dropped on overflow with a sticky flag.

---
 rtl/proc_io_pkg.sv | 12 +
 rtl/proc_out_fifo_mem.sv | 23 ++
 rtl/proc_out_fifo.sv | 84 ++++++++
 3 files changed

// File: rtl/proc_io_pkg.sv
// Shared definitions for the Processor's din/dout datapath and its I/O buffers.
package proc_io_pkg;

  localparam int PROC_DATA_W = 16;

  typedef logic [PROC_DATA_W-1:0] proc_word_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/proc_out_fifo_mem.sv
// Storage for proc_out_fifo: one synchronous write port, one asynchronous read port.
module proc_out_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (we) ram[wr_addr] <= wr_data;
  end

  assign rd_data = ram[rd_addr];

endmodule

// File: rtl/proc_out_fifo.sv
// First-word-fall-through output queue behind the Processor's dout port, with
// registered status flags and a sticky overflow flag for dropped writes.
module proc_out_fifo
  import proc_io_pkg::*;
#(
  parameter int DATA_W    = PROC_DATA_W,
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12,
  localparam int PW = ptr_w(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  logic [PW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]     count_after_pop, count_nxt;
  logic              push, pop, drop;
  logic [DATA_W-1:0] mem_rd;

  always_comb begin
    pop             = rd_valid & rd_ready;
    push            = wr_en & (~full | pop);
    drop            = wr_en & full & ~pop;
    rd_ptr_nxt      = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_after_pop = count - CW'(pop);
    count_nxt       = count_after_pop + CW'(push);
  end

  // Read address is the head after this edge, so rd_data can be registered.
  proc_out_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_mem (
    .clk     (clk),
    .we      (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_nxt),
    .rd_data (mem_rd)
  );

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      empty       <= 1'b1;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      full        <= (count_nxt == FULL_CNT);
      almost_full <= (count_nxt >= AFULL_CNT);
      empty       <= (count_nxt == '0);
      rd_valid    <= (count_nxt != '0);
      overflow    <= drop | (overflow & ~clr_ovf);
      // New head is the incoming word when nothing else survives the pop.
      if (push && count_after_pop == '0) rd_data <= wr_data;
      else if (count_after_pop != '0)    rd_data <= mem_rd;
    end
  end

endmodule
